nco_sweep_ctrl: RTL
===================

# nco_sweep_ctrl

Sequencer that drives the `phase_inc` input and the `rst` input of one `nco` instance to produce stepped-frequency sweeps. Software or a host FSM loads a sweep descriptor over a valid/ready port and issues `start`. The block then steps the tuning word through a programmed number of frequencies. At each step it waits out the NCO pipeline and flags the dwell window in which I/Q samples are valid. It sits between the control/register block and the `nco`, and the downstream correlator uses `iq_valid` and `step_idx` to bin samples.

## Interface
- `PHASE_ACC_BITS`, 24: must match the NCO; tuning word width is `PHASE_ACC_BITS-1`.
- `STEP_BITS`, 10: width of the step count and the step index.
- `DWELL_BITS`, 16: width of the dwell counter.
- `SETTLE_CYCLES`, 4: cycles from a `phase_inc` or `nco_rst` change until NCO I/Q reflect it; must be ≥1.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous and active-high.
- `cfg_valid` in 1: descriptor valid.
- `cfg_ready` out 1: descriptor accepted when `cfg_valid & cfg_ready` at a rising edge.
- `cfg_f_start` in `PHASE_ACC_BITS-1`: first tuning word.
- `cfg_f_step` in `PHASE_ACC_BITS-1`: step magnitude.
- `cfg_step_dn` in 1: 1 = sweep downward.
- `cfg_n_steps` in `STEP_BITS`: number of frequencies; 0 is treated as 1.
- `cfg_dwell` in `DWELL_BITS`: valid cycles per step; 0 is treated as 1.
- `cfg_loop` in 1: restart the sweep automatically after the last step.
- `start` in 1: single-cycle request to begin a sweep.
- `abort` in 1: stops the sweep immediately.
- `phase_inc` out `PHASE_ACC_BITS-1`: drives the NCO tuning word.
- `nco_rst` out 1: drives the NCO `rst` input.
- `iq_valid` out 1: NCO I/Q are valid for the current step.
- `step_idx` out `STEP_BITS`: index of the current step.
- `busy` out 1: a sweep is in progress.
- `done` out 1: one-cycle pulse at the end of each sweep pass.
- `sat` out 1: sticky flag, set when the tuning word saturated.

## Operation
- States are IDLE, ARM, SETTLE, DWELL, STEP.
- IDLE:
  - `cfg_ready`=1 and `nco_rst`=1.
  - An accepted descriptor is registered into the shadow config.
  - `start` moves to ARM using the shadow config as it stood before this edge. A descriptor accepted on the same edge applies to the next sweep only.
- ARM (1 cycle):
  - `phase_inc`←f_start, `step_idx`←0, `sat`←0.
  - `nco_rst` stays 1, so the NCO phase is zero at sweep start.
  - Next state is SETTLE.
- SETTLE:
  - `nco_rst`=0 and `iq_valid`=0.
  - Holds for exactly `SETTLE_CYCLES` cycles, then goes to DWELL.
- DWELL:
  - `iq_valid`=1 for exactly max(dwell,1) cycles.
  - Then: if `step_idx`≠max(n_steps,1)−1, go to STEP.
  - Else if `cfg_loop`=1: pulse `done`, reload `phase_inc`←f_start and `step_idx`←0, and go to SETTLE. `nco_rst` is not asserted and `sat` is not cleared.
  - Else: pulse `done` and go to IDLE.
- STEP (1 cycle):
  - `iq_valid`=0.
  - `phase_inc`←`phase_inc`±f_step, computed with one extra bit.
  - Up-sweep overflow above 2^(`PHASE_ACC_BITS`−1)−1 clamps to all-ones. Down-sweep underflow below 0 clamps to 0. Either case sets `sat`.
  - `step_idx`++, then go to SETTLE.
- `busy`=1 in every state except IDLE.
- `start` while `busy` is ignored.
- `cfg_valid` outside IDLE is not accepted: `cfg_ready`=0 and the shadow config is unchanged.
- `abort`:
  - From any non-IDLE state, goes to IDLE on the next edge.
  - `iq_valid`→0, `nco_rst`→1, no `done` pulse.
  - `phase_inc`, `step_idx` and `sat` hold their values.
  - `abort` wins over every transition on the same edge, including the `done` transition.
  - `abort` together with `start` in IDLE: no sweep starts.
- `rst` asserted mid-sweep forces IDLE asynchronously. No `done` pulse is produced and the shadow config is cleared.

## Timing
- All outputs are registered except `cfg_ready` and `busy`, which decode the state register.
- Reset values:
  - State IDLE, `cfg_ready`=1, `nco_rst`=1, `busy`=0.
  - `phase_inc`=0, `iq_valid`=0, `step_idx`=0, `done`=0, `sat`=0.
  - Shadow config all zeros.
- With `start` sampled at edge 0:
  - ARM occupies cycle 1.
  - SETTLE occupies cycles 2..1+`SETTLE_CYCLES`.
  - `iq_valid` first rises in cycle 2+`SETTLE_CYCLES`.
- Each step lasts `SETTLE_CYCLES`+dwell+1 cycles (the last step has no STEP cycle).
- `phase_inc` changes only on the edge that leaves ARM or STEP, or on the loop reload. It never changes while `iq_valid`=1.
- `done` is high for exactly the one cycle after the last DWELL cycle.
- On a non-loop sweep, `busy` falls in that same cycle.

## Test plan
- Basic up-sweep:
  - Stimulus: `SETTLE_CYCLES`=4; descriptor f_start=0x001000, f_step=0x000100, up, n_steps=3, dwell=2, loop=0; `start` at edge 0.
  - Required: `phase_inc` = 0x1000/0x1100/0x1200.
  - `iq_valid` high in cycles 6–7, 13–14 and 20–21; `step_idx` 0/1/2 during those windows.
  - `done` pulses in cycle 22; `busy` high in cycles 1–21.
- Saturation:
  - Stimulus: f_start=0x7FFF00, f_step=0x80, up, n_steps=3.
  - Required: `phase_inc` 0x7FFF00 → 0x7FFF80 → 0x7FFFFF; `sat`=1 after the second STEP.
  - Down variant: f_start=0x80, step 0x100 → 0x000000 and `sat`=1.
- Zero descriptors:
  - Stimulus: n_steps=0, dwell=0.
  - Required: a single step, `iq_valid` high for exactly 1 cycle, `done` one cycle later.
- Abort and restart:
  - Stimulus: `abort` during the second DWELL.
  - Required: IDLE next cycle, `iq_valid`=0, `nco_rst`=1, no `done`, `phase_inc` holds 0x1100.
  - A new `start` afterwards reproduces the basic up-sweep timing.
- Config and start collisions:
  - `start` with a new descriptor on the same edge: the sweep uses the old values, and the next sweep uses the new ones.
  - `cfg_valid` while `busy`: `cfg_ready`=0 and the shadow config is unchanged.
  - `start` while `busy` is ignored.
- Loop and reset:
  - Stimulus: loop=1, n_steps=2.
  - Required: `done` pulses once per pass, `busy` stays high, `phase_inc` reloads f_start without an `nco_rst` pulse.
  - Asserting `rst` asynchronously mid-pass returns every output to its reset value before the next edge.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
//   Stepped-frequency sweep sequencer for one NCO. A sweep descriptor is
//   loaded over a valid/ready port into a shadow register. On start, the
//   block steps the NCO tuning word through n_steps frequencies. At each
//   step it waits out the NCO pipeline and then flags the dwell window in
//   which I/Q samples are valid.
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   cfg_valid/ready   : descriptor handshake (accepted only in IDLE)
//   cfg_f_start/step  : first tuning word / step magnitude
//   cfg_step_dn       : 1 = sweep downward
//   cfg_n_steps       : number of frequencies (0 treated as 1)
//   cfg_dwell         : valid cycles per step (0 treated as 1)
//   cfg_loop          : restart automatically after the last step
//   start, abort      : begin sweep / stop immediately
//   phase_inc,nco_rst : NCO tuning word and NCO reset
//   iq_valid,step_idx : dwell window flag and current step index
//   busy, done, sat   : sweep active, end-of-pass pulse, sticky saturation
module nco_sweep_ctrl #(
  parameter int PHASE_ACC_BITS = 24,
  parameter int STEP_BITS      = 10,
  parameter int DWELL_BITS     = 16,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [PHASE_ACC_BITS-2:0] cfg_f_start,
  input  logic [PHASE_ACC_BITS-2:0] cfg_f_step,
  input  logic                      cfg_step_dn,
  input  logic [STEP_BITS-1:0]      cfg_n_steps,
  input  logic [DWELL_BITS-1:0]     cfg_dwell,
  input  logic                      cfg_loop,
  input  logic                      start,
  input  logic                      abort,
  output logic [PHASE_ACC_BITS-2:0] phase_inc,
  output logic                      nco_rst,
  output logic                      iq_valid,
  output logic [STEP_BITS-1:0]      step_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      sat
);

  localparam int W        = PHASE_ACC_BITS - 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CNT_W    = (DWELL_BITS > SETTLE_W) ? DWELL_BITS : SETTLE_W;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARM, SETTLE, DWELL, STEP} state_t;
  state_t state, next_state;

  // Shadow config is written by the handshake; the active copy is taken
  // from the shadow on the start edge, so a descriptor accepted on that
  // same edge only affects the following sweep.
  logic [W-1:0]          sh_f_start, sh_f_step, a_f_start, a_f_step;
  logic                  sh_dn, sh_loop, a_dn, a_loop;
  logic [STEP_BITS-1:0]  sh_n_steps, a_n_steps;
  logic [DWELL_BITS-1:0] sh_dwell, a_dwell;

  logic [CNT_W-1:0]      cnt;
  logic [STEP_BITS-1:0]  last_idx;
  logic [DWELL_BITS-1:0] dwell_last;
  logic [W:0]            sum_up, sum_dn;
  logic [W-1:0]          step_next;
  logic                  step_sat;
  logic                  capture, load_first, clear_sat, advance, end_pass;

  assign cfg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign last_idx   = (a_n_steps == '0) ? '0 : a_n_steps - STEP_BITS'(1);
  assign dwell_last = (a_dwell == '0) ? '0 : a_dwell - DWELL_BITS'(1);

  // One extra bit exposes carry (up) or borrow (down) for clamping.
  assign sum_up = {1'b0, phase_inc} + {1'b0, a_f_step};
  assign sum_dn = {1'b0, phase_inc} - {1'b0, a_f_step};

  always_comb begin
    step_next = '0;
    step_sat  = 1'b0;
    if (a_dn) begin
      step_sat  = sum_dn[W];
      step_next = sum_dn[W] ? '0 : sum_dn[W-1:0];
    end else begin
      step_sat  = sum_up[W];
      step_next = sum_up[W] ? '1 : sum_up[W-1:0];
    end
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    load_first = 1'b0;
    clear_sat  = 1'b0;
    advance    = 1'b0;
    end_pass   = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        next_state = ARM;
        capture    = 1'b1;
      end
      ARM: begin
        next_state = SETTLE;
        load_first = 1'b1;
        clear_sat  = 1'b1;
      end
      SETTLE: if (cnt == SETTLE_LAST) next_state = DWELL;
      DWELL: if (cnt == CNT_W'(dwell_last)) begin
        if (step_idx != last_idx) begin
          next_state = STEP;
        end else begin
          end_pass = 1'b1;
          if (a_loop) begin
            next_state = SETTLE;
            load_first = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      STEP: begin
        next_state = SETTLE;
        advance    = 1'b1;
      end
      default: next_state = IDLE;
    endcase
    // Abort overrides every transition and suppresses all datapath updates.
    if (abort && state != IDLE) begin
      next_state = IDLE;
      load_first = 1'b0;
      clear_sat  = 1'b0;
      advance    = 1'b0;
      end_pass   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      phase_inc <= '0;
      step_idx  <= '0;
      iq_valid  <= 1'b0;
      nco_rst   <= 1'b1;
      done      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      cnt      <= (next_state != state) ? '0 : cnt + CNT_W'(1);
      iq_valid <= (next_state == DWELL);
      nco_rst  <= (next_state == IDLE) || (next_state == ARM);
      done     <= end_pass;
      if (load_first) begin
        phase_inc <= a_f_start;
        step_idx  <= '0;
      end
      if (clear_sat) sat <= 1'b0;
      if (advance) begin
        phase_inc <= step_next;
        step_idx  <= step_idx + STEP_BITS'(1);
        if (step_sat) sat <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_f_start <= '0; sh_f_step <= '0; sh_dn <= 1'b0; sh_loop <= 1'b0;
      sh_n_steps <= '0; sh_dwell  <= '0;
      a_f_start  <= '0; a_f_step  <= '0; a_dn  <= 1'b0; a_loop  <= 1'b0;
      a_n_steps  <= '0; a_dwell   <= '0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        sh_f_start <= cfg_f_start;
        sh_f_step  <= cfg_f_step;
        sh_dn      <= cfg_step_dn;
        sh_loop    <= cfg_loop;
        sh_n_steps <= cfg_n_steps;
        sh_dwell   <= cfg_dwell;
      end
      if (capture) begin
        a_f_start <= sh_f_start;
        a_f_step  <= sh_f_step;
        a_dn      <= sh_dn;
        a_loop    <= sh_loop;
        a_n_steps <= sh_n_steps;
        a_dwell   <= sh_dwell;
      end
    end
  end

endmodule
